// File: rtl/x_top_rv32i_rf_mp.sv
// Multi-read-port rv32i register file: NRD registered read ports, one write port,
// write-first bypass, read hold, and an optional post-reset clear sweep.

module x_rf_rd_port #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic            i_hold,
  input  logic            i_clr,
  input  logic [AW-1:0]   i_addr,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data,
  output logic [XLEN-1:0] o_data
);
  logic in_range;
  assign in_range = (i_addr != '0) && (32'(i_addr) < NREG);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)                                o_data <= '0;
    else if (i_clr)                             o_data <= '0;
    else if (!i_hold) begin
      if (!in_range)                            o_data <= '0;
      else if (i_wr_en && i_wr_addr == i_addr)  o_data <= i_wr_data;
      else                                      o_data <= i_mem_data;
    end
  end
endmodule

module x_top_rv32i_rf_mp #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int NRD        = 2,
  parameter int CLR_ON_RST = 1,
  localparam int AW        = (NREG > 2) ? $clog2(NREG) : 1
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  logic                i_hold,
  input  logic [NRD*AW-1:0]   i_rs,
  output logic [NRD*XLEN-1:0] o_rs_data,
  input  logic                i_we,
  input  logic [AW-1:0]       i_rd,
  input  logic [XLEN-1:0]     i_rd_data,
  output logic                o_busy
);
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  typedef struct packed {
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_req_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  wr_req_t       wr_run, wr_mem;

  logic [XLEN-1:0]           mem [NREG];
  logic [NRD-1:0][AW-1:0]    rs_v;
  logic [NRD-1:0][XLEN-1:0]  rdat;
  logic [NRD-1:0][XLEN-1:0]  rd_q;

  assign rs_v      = i_rs;
  assign o_rs_data = rd_q;
  assign o_busy    = (state_q == S_CLEAR);

  // Writes to x0 or past the last register are dropped, never aliased.
  assign wr_run.en   = i_we && (i_rd != '0) && (32'(i_rd) < NREG);
  assign wr_run.addr = i_rd;
  assign wr_run.data = i_rd_data;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= (CLR_ON_RST != 0) ? S_CLEAR : S_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // While clearing, the sweep owns the write port and external writes are lost.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_mem    = wr_run;
    if (state_q == S_CLEAR) begin
      wr_mem.en   = 1'b1;
      wr_mem.addr = clr_cnt_q;
      wr_mem.data = '0;
      if (clr_cnt_q == AW'(NREG - 1)) state_d   = S_RUN;
      else                            clr_cnt_d = clr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_mem.en) mem[wr_mem.addr] <= wr_mem.data;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    assign rdat[k] = (32'(rs_v[k]) < NREG) ? mem[rs_v[k]] : '0;

    x_rf_rd_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_port (
      .i_clk      (i_clk),
      .i_nrst     (i_nrst),
      .i_hold     (i_hold),
      .i_clr      (state_q == S_CLEAR),
      .i_addr     (rs_v[k]),
      .i_mem_data (rdat[k]),
      .i_wr_en    (wr_run.en),
      .i_wr_addr  (wr_run.addr),
      .i_wr_data  (wr_run.data),
      .o_data     (rd_q[k])
    );
  end
endmodule

// File: tb/tb_x_top_rv32i_rf_mp.sv
// Bench for x_top_rv32i_rf_mp: directed scenarios plus random traffic against an array model.

module tb_x_top_rv32i_rf_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: NREG = 32
  logic        nrst_a, hold_a, we_a, busy_a;
  logic [9:0]  rs_a;
  logic [4:0]  rd_a;
  logic [31:0] wd_a;
  logic [63:0] rsd_a;

  // DUT B: NREG = 24 (non-power-of-2)
  logic        nrst_b, hold_b, we_b, busy_b;
  logic [9:0]  rs_b;
  logic [4:0]  rd_b;
  logic [31:0] wd_b;
  logic [63:0] rsd_b;

  x_top_rv32i_rf_mp #(.XLEN(32), .NREG(32), .NRD(2), .CLR_ON_RST(1)) u_dut_a (
    .i_clk(clk), .i_nrst(nrst_a), .i_hold(hold_a), .i_rs(rs_a), .o_rs_data(rsd_a),
    .i_we(we_a), .i_rd(rd_a), .i_rd_data(wd_a), .o_busy(busy_a));

  x_top_rv32i_rf_mp #(.XLEN(32), .NREG(24), .NRD(2), .CLR_ON_RST(1)) u_dut_b (
    .i_clk(clk), .i_nrst(nrst_b), .i_hold(hold_b), .i_rs(rs_b), .o_rs_data(rsd_b),
    .i_we(we_b), .i_rd(rd_b), .i_rd_data(wd_b), .o_busy(busy_b));

  int errors = 0;
  int checks = 0;

  // Reference model for DUT A: register contents and the expected registered outputs.
  logic [31:0] mem_m [32];
  logic [31:0] out_m [2];

  // One cycle on DUT A; the model follows the register-file rules directly.
  task automatic cyc_a(input logic h, input logic [4:0] a0, input logic [4:0] a1,
                       input logic we, input logic [4:0] rd, input logic [31:0] d);
    logic [4:0] a [2];
    a[0] = a0; a[1] = a1;
    hold_a = h; rs_a = {a1, a0}; we_a = we; rd_a = rd; wd_a = d;
    for (int k = 0; k < 2; k++) begin
      if (!h) begin
        if (a[k] == 5'd0)             out_m[k] = 32'h0;
        else if (we && rd == a[k])    out_m[k] = d;
        else                          out_m[k] = mem_m[a[k]];
      end
    end
    if (we && rd != 5'd0) mem_m[rd] = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    nrst_a = 1'b0; nrst_b = 1'b0;
    hold_a = 0; rs_a = '0; we_a = 0; rd_a = '0; wd_a = '0;
    hold_b = 0; rs_b = '0; we_b = 0; rd_b = '0; wd_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rsd_a !== 64'h0) begin errors++; $display("FAIL reset_data_a got=%h exp=0", rsd_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_busy_a got=%b exp=1", busy_a); end
    checks++; if (rsd_b !== 64'h0) begin errors++; $display("FAIL reset_data_b got=%h exp=0", rsd_b); end
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL reset_busy_b got=%b exp=1", busy_b); end
  endtask

  task automatic test_clear();
    int cnt = 0;
    nrst_a = 1'b1;
    while (busy_a === 1'b1 && cnt < 100) begin
      cnt++;
      we_a = (cnt == 3); rd_a = 5'd5; wd_a = 32'hDEADBEEF;
      @(posedge clk); #1;
    end
    we_a = 1'b0;
    checks++; if (cnt != 32) begin errors++; $display("FAIL clear_busy_len got=%0d exp=32", cnt); end
    checks++; if (rsd_a !== 64'h0) begin errors++; $display("FAIL clear_out got=%h exp=0", rsd_a); end
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
    out_m[0] = 32'h0; out_m[1] = 32'h0;
    cyc_a(0, 5'd5, 5'd5, 0, 5'd0, 32'h0);
    checks++; if (rsd_a !== 64'h0) begin errors++; $display("FAIL clear_x5_dropped got=%h exp=0", rsd_a); end
  endtask

  task automatic test_basic();
    cyc_a(0, 5'd0, 5'd0, 1, 5'd1, 32'h12345678);
    cyc_a(0, 5'd0, 5'd0, 1, 5'd31, 32'hFFFFFFFF);
    cyc_a(0, 5'd1, 5'd31, 0, 5'd0, 32'h0);
    checks++;
    if (rsd_a !== {32'hFFFFFFFF, 32'h12345678}) begin
      errors++; $display("FAIL basic_rw got=%h exp=%h", rsd_a, {32'hFFFFFFFF, 32'h12345678});
    end
  endtask

  task automatic test_x0();
    cyc_a(0, 5'd0, 5'd0, 1, 5'd0, 32'hA5A5A5A5);
    checks++; if (rsd_a !== 64'h0) begin errors++; $display("FAIL x0_same got=%h exp=0", rsd_a); end
    cyc_a(0, 5'd0, 5'd0, 0, 5'd0, 32'h0);
    checks++; if (rsd_a !== 64'h0) begin errors++; $display("FAIL x0_next got=%h exp=0", rsd_a); end
  endtask

  task automatic test_bypass();
    cyc_a(0, 5'd0, 5'd0, 1, 5'd7, 32'h1);
    cyc_a(0, 5'd7, 5'd7, 1, 5'd7, 32'hCAFEF00D);
    checks++;
    if (rsd_a !== {32'hCAFEF00D, 32'hCAFEF00D}) begin
      errors++; $display("FAIL bypass got=%h exp=%h", rsd_a, {32'hCAFEF00D, 32'hCAFEF00D});
    end
    cyc_a(0, 5'd7, 5'd0, 0, 5'd0, 32'h0);
    checks++; if (rsd_a[31:0] !== 32'hCAFEF00D) begin errors++; $display("FAIL bypass_stored got=%h exp=cafef00d", rsd_a[31:0]); end
  endtask

  task automatic test_hold();
    cyc_a(0, 5'd0, 5'd0, 1, 5'd2, 32'h22);
    cyc_a(0, 5'd0, 5'd0, 1, 5'd3, 32'h33);
    cyc_a(0, 5'd2, 5'd3, 0, 5'd0, 32'h0);
    checks++; if (rsd_a[31:0] !== 32'h22) begin errors++; $display("FAIL hold_pre got=%h exp=22", rsd_a[31:0]); end
    for (int i = 0; i < 3; i++) begin
      cyc_a(1, 5'd3, 5'd2, (i == 0), 5'd2, 32'h99);
      checks++;
      if (rsd_a !== {32'h33, 32'h22}) begin
        errors++; $display("FAIL hold_cycle%0d got=%h exp=%h", i, rsd_a, {32'h33, 32'h22});
      end
    end
    cyc_a(0, 5'd2, 5'd0, 0, 5'd0, 32'h0);
    checks++; if (rsd_a[31:0] !== 32'h99) begin errors++; $display("FAIL hold_write got=%h exp=99", rsd_a[31:0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic h, we;
      logic [4:0] a0, a1, rd;
      logic [31:0] d;
      h  = ($urandom_range(0, 4) == 0);
      we = $urandom_range(0, 1);
      rd = 5'($urandom_range(0, 31));
      // Bias reads toward the write address so bypass gets exercised.
      a0 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      d  = $urandom;
      cyc_a(h, a0, a1, we, rd, d);
      checks++;
      if (rsd_a !== {out_m[1], out_m[0]}) begin
        errors++; $display("FAIL random_cyc%0d got=%h exp=%h", n, rsd_a, {out_m[1], out_m[0]});
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt = 0;
    nrst_b = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL midclr_busy got=%b exp=1", busy_b); end
    nrst_b = 1'b0;
    @(posedge clk); #1;
    nrst_b = 1'b1;
    while (busy_b === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    checks++; if (cnt != 24) begin errors++; $display("FAIL midclr_busy_len got=%0d exp=24", cnt); end
    we_b = 1'b1; rd_b = 5'd27; wd_b = 32'h5; rs_b = {5'd27, 5'd27};
    @(posedge clk); #1;
    we_b = 1'b0;
    checks++; if (rsd_b !== 64'h0) begin errors++; $display("FAIL oor_bypass got=%h exp=0", rsd_b); end
    @(posedge clk); #1;
    checks++; if (rsd_b !== 64'h0) begin errors++; $display("FAIL oor_read got=%h exp=0", rsd_b); end
    for (int i = 1; i < 24; i++) begin
      rs_b = {5'(i), 5'(i)};
      @(posedge clk); #1;
      checks++; if (rsd_b !== 64'h0) begin errors++; $display("FAIL oor_x%0d got=%h exp=0", i, rsd_b); end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_basic();
    test_x0();
    test_bypass();
    test_hold();
    test_random();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
